// File: rtl/shiftrow_stream_if.sv
// Valid/ready stream carrying one Rijndael state block of 32*NB bits.
// With SHIFTROW_INV_EN defined, each block also carries an inverse-mode bit.
interface shiftrow_stream_if #(
    parameter int NB = 4
);
    logic              valid;
    logic              ready;
    logic [32*NB-1:0]  data;
`ifdef SHIFTROW_INV_EN
    logic              inv;

    modport master (output valid, output data, output inv, input ready);
    modport slave  (input valid, input data, input inv, output ready);
`else
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
`endif
endinterface

// File: rtl/shiftrow_stream.sv
// Streaming Rijndael ShiftRows stage (NB = 4/6/8 columns) behind a 2-entry
// skid buffer. The permutation is applied on the input side, so the buffer
// holds already-shifted blocks. in_ready is a register and never depends
// combinationally on out_ready.
// Optional feature macro: SHIFTROW_INV_EN adds a per-block inverse select
// (InvShiftRows) that travels with its block through the buffer.
//
// state | meaning
// EMPTY | no block buffered, out_valid low
// ONE   | one block buffered, it is the head presented downstream
// TWO   | two blocks buffered, input is blocked
module shiftrow_stream #(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    shiftrow_stream_if.slave   in_bus,
    shiftrow_stream_if.master  out_bus,
    output logic [CNT_W-1:0]   blk_count
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shiftrow_stream: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           push;
    logic           pop;
    logic           in_ready_q;
    logic [W-1:0]   fwd_data;
    logic [W-1:0]   shifted;
    logic [W-1:0]   head_data;
    logic [W-1:0]   tail_data;

    // Fixed byte wiring: output byte (r,c) takes input column (c +/- s(r)) mod NB.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int S = (NB == 8 && r >= 2) ? r + 1 : r;
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FS = (c + S) % NB;
            assign fwd_data[W-1-8*(4*c+r) -: 8] = in_bus.data[W-1-8*(4*FS+r) -: 8];
        end
    end

`ifdef SHIFTROW_INV_EN
    logic [W-1:0]   inv_data;
    logic           head_inv;
    logic           tail_inv;

    for (genvar r = 0; r < 4; r++) begin : g_irow
        localparam int S = (NB == 8 && r >= 2) ? r + 1 : r;
        for (genvar c = 0; c < NB; c++) begin : g_icol
            localparam int IS = (c + NB - S) % NB;
            assign inv_data[W-1-8*(4*c+r) -: 8] = in_bus.data[W-1-8*(4*IS+r) -: 8];
        end
    end

    assign shifted     = in_bus.inv ? inv_data : fwd_data;
    assign out_bus.inv = head_inv;

    // Mode bit follows the same head/tail movement as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_inv <= 1'b0;
            tail_inv <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) head_inv <= in_bus.inv;
                ONE: begin
                    if (push && pop)  head_inv <= in_bus.inv;
                    else if (push)    tail_inv <= in_bus.inv;
                end
                TWO:   if (pop) head_inv <= tail_inv;
                default: ;
            endcase
        end
    end
`else
    assign shifted = fwd_data;
`endif

    // State register; in_ready is registered from the upcoming occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // Next-state logic for the buffer occupancy.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:   if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake decode and output drive.
    always_comb begin
        push          = in_bus.valid & in_ready_q;
        pop           = (state != EMPTY) & out_bus.ready;
        out_bus.valid = (state != EMPTY);
        out_bus.data  = head_data;
        in_bus.ready  = in_ready_q;
    end

    // Buffer storage: head is always the oldest block.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case (state)
                EMPTY: if (push) head_data <= shifted;
                ONE: begin
                    if (push && pop)  head_data <= shifted;
                    else if (push)    tail_data <= shifted;
                end
                TWO:   if (pop) head_data <= tail_data;
                default: ;
            endcase
        end
    end

    // Completed output transfers, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)      blk_count <= '0;
        else if (pop) blk_count <= blk_count + 1'b1;
    end
endmodule

// File: tb/tb_shiftrow_stream.sv
// Scoreboard bench for shiftrow_stream: accepted inputs push a model result,
// output monitors pop and compare. Inverse-mode checks need SHIFTROW_INV_EN.
`timescale 1ns/1ps
module tb_shiftrow_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shiftrow_stream_if #(.NB(4)) i4 ();
    shiftrow_stream_if #(.NB(4)) o4 ();
    shiftrow_stream_if #(.NB(6)) i6 ();
    shiftrow_stream_if #(.NB(6)) o6 ();
    shiftrow_stream_if #(.NB(8)) i8 ();
    shiftrow_stream_if #(.NB(8)) o8 ();

    logic [7:0]  blk4;
    logic [15:0] blk6;
    logic [15:0] blk8;

    shiftrow_stream #(.NB(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst), .in_bus(i4), .out_bus(o4), .blk_count(blk4));
    shiftrow_stream #(.NB(6))            u6 (.clk(clk), .rst(rst), .in_bus(i6), .out_bus(o6), .blk_count(blk6));
    shiftrow_stream #(.NB(8))            u8 (.clk(clk), .rst(rst), .in_bus(i8), .out_bus(o8), .blk_count(blk8));

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] q4[$];
    logic [191:0] q6[$];
    logic [255:0] q8[$];
    logic [7:0]   exp_cnt4 = '0;
    int           total4 = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic [191:0] last6 = '0;
    logic [255:0] last8 = '0;
    logic [255:0] t4, t6, t8;
    logic         inv4;

`ifdef SHIFTROW_INV_EN
    assign inv4 = i4.inv;
`else
    assign inv4 = 1'b0;
`endif

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ShiftRows on a block right-aligned in 256 bits.
    function automatic logic [255:0] model(input logic [255:0] d, input int nb, input logic inv);
        logic [7:0]   b[32];
        logic [255:0] o;
        int           sh[4];
        int           r, c, src;
        o = '0;
        if (nb == 8) sh = '{0, 1, 3, 4};
        else         sh = '{0, 1, 2, 3};
        for (int k = 0; k < 4*nb; k++) b[k] = d[32*nb-1-8*k -: 8];
        for (int k = 0; k < 4*nb; k++) begin
            r   = k % 4;
            c   = k / 4;
            src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
            o[32*nb-1-8*k -: 8] = b[4*src + r];
        end
        return o;
    endfunction

    // Stimulus side: every accepted block queues its expected output.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete(); q6.delete(); q8.delete();
        end else begin
            if (i4.valid && i4.ready) begin
                t4 = model({128'b0, i4.data}, 4, inv4);
                q4.push_back(t4[127:0]);
            end
            if (i6.valid && i6.ready) begin
                t6 = model({64'b0, i6.data}, 6, 1'b0);
                q6.push_back(t6[191:0]);
            end
            if (i8.valid && i8.ready) begin
                t8 = model(i8.data, 8, 1'b0);
                q8.push_back(t8);
            end
        end
    end

    // NB=4 monitor: ordering, data, hold-while-stalled, transfer count.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt4   = '0;
            prev_stall = 1'b0;
        end else begin
            check("blk_count", {248'b0, blk4}, {248'b0, exp_cnt4});
            if (prev_stall) begin
                check("hold_valid", {255'b0, o4.valid}, 256'd1);
                check("hold_data", {128'b0, o4.data}, {128'b0, prev_data});
            end
            if (o4.valid && o4.ready) begin
                if (q4.size() == 0) check("unexpected_out4", {128'b0, o4.data}, 256'b0 - 1);
                else                check("out4", {128'b0, o4.data}, {128'b0, q4.pop_front()});
                exp_cnt4 = exp_cnt4 + 8'd1;
                total4++;
            end
            prev_stall = o4.valid && !o4.ready;
            prev_data  = o4.data;
        end
    end

    // NB=6 / NB=8 monitors.
    always @(negedge clk) begin
        if (!rst && o6.valid && o6.ready) begin
            last6 = o6.data;
            if (q6.size() == 0) check("unexpected_out6", {64'b0, o6.data}, 256'b0 - 1);
            else                check("out6", {64'b0, o6.data}, {64'b0, q6.pop_front()});
        end
        if (!rst && o8.valid && o8.ready) begin
            last8 = o8.data;
            if (q8.size() == 0) check("unexpected_out8", o8.data, 256'b0 - 1);
            else                check("out8", o8.data, q8.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send4(input logic [127:0] d, input logic inv);
        bit done = 0;
        i4.valid = 1'b1;
        i4.data  = d;
`ifdef SHIFTROW_INV_EN
        i4.inv   = inv;
`endif
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (i4.ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("send4_timeout", 256'd0, 256'd1);
        i4.valid = 1'b0;
        if (inv) i4.valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] VEC_INV = 128'h000d0a0704010e0b0805020f0c090603;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] d6;
        logic [255:0] d8;
        bit           done;
        i4.valid = 0; i4.data = '0; o4.ready = 0;
        i6.valid = 0; i6.data = '0; o6.ready = 1;
        i8.valid = 0; i8.data = '0; o8.ready = 1;
`ifdef SHIFTROW_INV_EN
        i4.inv = 0; i6.inv = 0; i8.inv = 0;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {255'b0, o4.valid}, 256'd0);
        check("rst_in_ready", {255'b0, i4.ready}, 256'd0);
        check("rst_out_data", {128'b0, o4.data}, 256'd0);
        check("rst_blk_count", {248'b0, blk4}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_low_before_edge", {255'b0, i4.ready}, 256'd0);
        @(negedge clk);
        check("in_ready_after_rst", {255'b0, i4.ready}, 256'd1);
        @(posedge clk); #1;

        // Forward NB=4 vector, one-cycle latency
        o4.ready = 1'b1;
        send4(VEC_IN, 1'b0);
        @(negedge clk);
        check("fwd_latency_valid", {255'b0, o4.valid}, 256'd1);
        check("fwd_vector", {128'b0, o4.data}, {128'b0, VEC_FWD});
        @(negedge clk);
        check("fwd_drained", {255'b0, o4.valid}, 256'd0);
        check("fwd_blk_count", {248'b0, blk4}, 256'd1);
        @(posedge clk); #1;

`ifdef SHIFTROW_INV_EN
        // Inverse vector and fwd-then-inv identity, held at the head for inspection
        o4.ready = 1'b0;
        send4(VEC_IN, 1'b1);
        @(negedge clk);
        check("inv_vector", {128'b0, o4.data}, {128'b0, VEC_INV});
        @(posedge clk); #1;
        o4.ready = 1'b1;
        cycles(2);
        o4.ready = 1'b0;
        send4(VEC_FWD, 1'b1);
        @(negedge clk);
        check("fwd_inv_identity", {128'b0, o4.data}, {128'b0, VEC_IN});
        @(posedge clk); #1;
        o4.ready = 1'b1;
        cycles(2);
`endif

        // NB=8 and NB=6 with byte k = k
        for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
        for (int k = 0; k < 24; k++) d6[191-8*k -: 8] = 8'(k);
        i8.data = d8; i6.data = d6;
        i8.valid = 1'b1; i6.valid = 1'b1;
        @(negedge clk);
        check("nb8_ready", {255'b0, i8.ready}, 256'd1);
        check("nb6_ready", {255'b0, i6.ready}, 256'd1);
        @(posedge clk); #1;
        i8.valid = 1'b0; i6.valid = 1'b0;
        cycles(3);
        check("nb8_r3c0", {248'b0, last8[231:224]}, 256'h13);
        check("nb6_r3c0", {248'b0, last6[167:160]}, 256'h0f);
        check("nb8_blk_count", {240'b0, blk8}, 256'd1);
        check("nb6_blk_count", {240'b0, blk6}, 256'd1);

        // Stall: A, B accepted, C refused while held; release drains A, B, C in order
        o4.ready = 1'b0;
        send4(VEC_IN, 1'b0);
        send4(128'h112233445566778899aabbccddeeff00, 1'b0);
        i4.valid = 1'b1;
        i4.data  = 128'hfedcba98765432100123456789abcdef;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", {255'b0, i4.ready}, 256'd0);
            check("stall_head", {128'b0, o4.data}, {128'b0, VEC_FWD});
            @(posedge clk); #1;
        end
        o4.ready = 1'b1;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (i4.ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("stall_c_timeout", 256'd0, 256'd1);
        i4.valid = 1'b0;
        cycles(4);
        check("stall_drained", q4.size(), 256'd0);

        // Reset while two blocks are held
        o4.ready = 1'b0;
        send4(128'hdeadbeef000000000000000000000001, 1'b0);
        send4(128'hcafef00d000000000000000000000002, 1'b0);
        @(negedge clk);
        check("two_held_valid", {255'b0, o4.valid}, 256'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        o4.ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {255'b0, o4.valid}, 256'd0);
        check("midrst_blk_count", {248'b0, blk4}, 256'd0);
        check("midrst_in_ready", {255'b0, i4.ready}, 256'd0);
        @(negedge clk);
        check("midrst_in_ready_rise", {255'b0, i4.ready}, 256'd1);
        @(posedge clk); #1;
        send4(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
        cycles(3);
        check("post_rst_drained", q4.size(), 256'd0);

        // Random stress, long enough for the 8-bit counter to wrap
        total4 = 0;
        for (int k = 0; k < 800; k++) begin
            i4.valid = 1'($urandom_range(0, 1));
            i4.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef SHIFTROW_INV_EN
            i4.inv   = 1'($urandom_range(0, 1));
`endif
            o4.ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        i4.valid = 1'b0;
        o4.ready = 1'b1;
        cycles(5);
        check("stress_drained", q4.size(), 256'd0);
        check("stress_wrapped", {255'b0, total4 > 256}, 256'd1);
        check("nb6_nb8_queues", q6.size() + q8.size(), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
